// File: rtl/oled_count_display_sched.sv
// Sequencer for the OLED character writer. It runs init and a full clear, then shows
// a 32-bit count as decimal digits on one 16x16 text line each time an update is requested.
module oled_count_display_sched #(
    parameter int          NUM_DIG    = 8,
    parameter int          LINE_Y     = 2,
    parameter int          CHAR_BLANK = 10,
    parameter bit          LZ_BLANK   = 1'b1,
    parameter logic [19:0] TIMEOUT    = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_req,
    input  logic [31:0] upd_val,
    input  logic        oled_done,
    output logic        oled_en,
    output logic [3:0]  oled_cmd,
    output logic [4:0]  oled_char_addr,
    output logic [7:0]  oled_x,
    output logic [2:0]  oled_y,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int          BCD_W     = NUM_DIG * 4;
    localparam int          K_W       = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [31:0] MAX_VAL   = 32'd99_999_999;
    localparam logic [3:0]  CMD_INIT  = 4'd0;
    localparam logic [3:0]  CMD_CLEAR = 4'd1;
    localparam logic [3:0]  CMD_WRITE = 4'd2;

    typedef enum logic [3:0] {
        S_INIT, S_GAP_INIT, S_CLS, S_GAP_CLS, S_IDLE, S_CONV, S_WR, S_GAP_WR, S_GAP_TO
    } state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [4:0]         char_q, char_d;
    logic [7:0]         x_q, x_d;
    logic [2:0]         y_q, y_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               pending_q, pending_d;
    logic [31:0]        pend_val_q, pend_val_d;
    logic [31:0]        bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [19:0]        wdog_q, wdog_d;

    logic               launch;
    logic [3:0]         launch_cmd;
    logic [K_W-1:0]     launch_k;
    logic [31:0]        src_val;
    logic [BCD_W-1:0]   bcd_adj;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Digit 0 is the most significant; blank it while every digit up to it is still zero.
    function automatic logic [4:0] digit_char(input logic [BCD_W-1:0] b, input logic [K_W-1:0] k);
        logic       lead;
        logic [3:0] d;
        lead = 1'b1;
        d    = '0;
        for (int j = 0; j < NUM_DIG; j++) begin
            if (j <= int'(k)) begin
                d = b[(NUM_DIG-1-j)*4 +: 4];
                if (d != 4'd0) lead = 1'b0;
            end
        end
        if (LZ_BLANK && (int'(k) < NUM_DIG - 1) && lead) return 5'(CHAR_BLANK);
        return {1'b0, d};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            en_q       <= 1'b0;
            cmd_q      <= '0;
            char_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            pending_q  <= 1'b0;
            pend_val_q <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            cmd_q      <= cmd_d;
            char_q     <= char_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            pending_q  <= pending_d;
            pend_val_q <= pend_val_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            wdog_q     <= wdog_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        cmd_d      = cmd_q;
        char_d     = char_q;
        x_d        = x_q;
        y_d        = y_q;
        ready_d    = ready_q;
        err_d      = err_q;
        pending_d  = pending_q;
        pend_val_d = pend_val_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        wdog_d     = wdog_q;
        launch     = 1'b0;
        launch_cmd = CMD_INIT;
        launch_k   = k_q;
        src_val    = upd_req ? upd_val : pend_val_q;
        bcd_adj    = add3(bcd_q);

        case (state_q)
            S_INIT, S_CLS, S_WR: begin
                if (!en_q) begin
                    launch     = 1'b1;
                    launch_cmd = (state_q == S_INIT) ? CMD_INIT :
                                 (state_q == S_CLS)  ? CMD_CLEAR : CMD_WRITE;
                end else if (oled_done) begin
                    en_d    = 1'b0;
                    state_d = (state_q == S_INIT) ? S_GAP_INIT :
                              (state_q == S_CLS)  ? S_GAP_CLS : S_GAP_WR;
                end else if (wdog_q == TIMEOUT - 20'd1) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    ready_d = 1'b0;
                    state_d = S_GAP_TO;
                end
            end
            S_GAP_INIT: begin
                state_d    = S_CLS;
                launch     = 1'b1;
                launch_cmd = CMD_CLEAR;
            end
            S_GAP_CLS: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            S_IDLE: begin
                if (upd_req || pending_q) begin
                    bin_d     = (src_val > MAX_VAL) ? MAX_VAL : src_val;
                    bcd_d     = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[31]};
                bin_d = {bin_q[30:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    k_d     = '0;
                    state_d = S_WR;
                end
            end
            S_GAP_WR: begin
                if (k_q == K_W'(NUM_DIG - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    k_d        = k_q + 1'b1;
                    state_d    = S_WR;
                    launch     = 1'b1;
                    launch_cmd = CMD_WRITE;
                    launch_k   = k_q + 1'b1;
                end
            end
            S_GAP_TO: begin
                state_d    = S_INIT;
                launch     = 1'b1;
                launch_cmd = CMD_INIT;
            end
            default: state_d = S_INIT;
        endcase

        // Command fields change only together with the enable rising, so they never move under en.
        if (launch) begin
            en_d   = 1'b1;
            wdog_d = '0;
            cmd_d  = launch_cmd;
            x_d    = '0;
            y_d    = '0;
            char_d = '0;
            if (launch_cmd == CMD_WRITE) begin
                x_d    = 8'(launch_k) << 4;
                y_d    = 3'(LINE_Y);
                char_d = digit_char(bcd_q, launch_k);
            end
        end else if (en_q) begin
            wdog_d = wdog_q + 20'd1;
        end

        if (upd_req && ((state_q != S_IDLE) || !ready_q)) begin
            pending_d  = 1'b1;
            pend_val_d = upd_val;
        end
    end

    assign oled_en        = en_q;
    assign oled_cmd       = cmd_q;
    assign oled_char_addr = char_q;
    assign oled_x         = x_q;
    assign oled_y         = y_q;
    assign ready          = ready_q;
    assign busy           = (state_q != S_IDLE);
    assign err            = err_q;

endmodule

// File: tb/tb_oled_count_display_sched.sv
// Self-checking bench for oled_count_display_sched: a writer model answers each command
// after a fixed delay while a monitor logs every command the sequencer issues.
module tb_oled_count_display_sched;
    localparam int TMO      = 200;
    localparam int DONE_DLY = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        upd_req;
    logic [31:0] upd_val;
    logic        oled_done;
    logic        oled_en;
    logic [3:0]  oled_cmd;
    logic [4:0]  oled_char_addr;
    logic [7:0]  oled_x;
    logic [2:0]  oled_y;
    logic        ready;
    logic        busy;
    logic        err;

    logic withhold  = 1'b0;
    logic forceDone = 1'b0;
    logic modelDone = 1'b0;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] x;
        logic [2:0] y;
        logic [4:0] ch;
    } wr_t;

    typedef struct {
        logic [31:0] val;
        string       expChars;
    } vec_t;

    wr_t logQ[$];
    int  gapQ[$];
    int  hiQ[$];
    int  stabErr = 0;
    int  nTests  = 0;
    int  nFail   = 0;

    assign oled_done = modelDone | forceDone;

    oled_count_display_sched #(.TIMEOUT(20'(TMO))) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .upd_req        (upd_req),
        .upd_val        (upd_val),
        .oled_done      (oled_done),
        .oled_en        (oled_en),
        .oled_cmd       (oled_cmd),
        .oled_char_addr (oled_char_addr),
        .oled_x         (oled_x),
        .oled_y         (oled_y),
        .ready          (ready),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Writer model: one-cycle done pulse on the 50th cycle of en, unless withheld.
    initial begin
        int modelCnt;
        modelCnt = 0;
        forever begin
            @(negedge clk);
            if (oled_en) begin
                modelCnt++;
                modelDone = (modelCnt == DONE_DLY) && !withhold;
            end else begin
                modelCnt  = 0;
                modelDone = 1'b0;
            end
        end
    end

    // Monitor: log each command at en rise with the en-low run before it and en-high run length.
    initial begin
        wr_t  cur, held;
        logic prevEn;
        int   lowRun, highRun;
        prevEn = 1'b0; lowRun = 0; highRun = 0; held = '0;
        forever begin
            @(negedge clk);
            cur = {oled_cmd, oled_x, oled_y, oled_char_addr};
            if (oled_en) begin
                if (!prevEn) begin
                    logQ.push_back(cur);
                    gapQ.push_back(lowRun);
                    held    = cur;
                    highRun = 0;
                end else if (cur != held) begin
                    stabErr++;
                end
                highRun++;
                lowRun = 0;
            end else begin
                if (prevEn) hiQ.push_back(highRun);
                lowRun++;
            end
            prevEn = oled_en;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] expectChar(input string s, input int k);
        byte c;
        c = s[k];
        if (c == "_") return 5'd10;
        return 5'(c - 8'd48);
    endfunction

    // Pulses a request and returns the number of clock edges until en is first seen high.
    task automatic applyStimulus(input logic [31:0] val, output int lat);
        @(negedge clk);
        upd_req = 1'b1;
        upd_val = val;
        @(posedge clk);
        #1;
        upd_req = 1'b0;
        lat = 1;
        while (!oled_en && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pulseReq(input logic [31:0] val);
        @(negedge clk);
        upd_req = 1'b1;
        upd_val = val;
        @(negedge clk);
        upd_req = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int maxCyc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " idle"}, busy, 0);
    endtask

    task automatic waitLog(input string tag, input int count, input int maxCyc);
        int n;
        n = 0;
        while (logQ.size() < count && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " cmds"}, logQ.size() >= count, 1);
    endtask

    task automatic checkRefresh(input string tag, input int base, input string exp);
        wr_t e;
        int  bad;
        checkOutput({tag, " count"}, logQ.size() >= base + 8, 1);
        for (int k = 0; k < 8; k++) begin
            e = {4'd2, 8'(k * 16), 3'd2, expectChar(exp, k)};
            checkOutput($sformatf("%s wr%0d", tag, k), logQ[base + k], e);
        end
        bad = 0;
        for (int k = 1; k < 8; k++) begin
            if (gapQ[base + k] != 1) bad++;
        end
        checkOutput({tag, " gaps"}, bad, 0);
    endtask

    initial begin
        vec_t vecs[7];
        logic e1, e2;
        int   lat, base, n;

        vecs[0] = '{32'd1234,         "____1234"};
        vecs[1] = '{32'd0,            "_______0"};
        vecs[2] = '{32'hFFFF_FFFF,    "99999999"};
        vecs[3] = '{32'd100_000_000,  "99999999"};
        vecs[4] = '{32'd10_000_000,   "10000000"};
        vecs[5] = '{32'd90807,        "___90807"};
        vecs[6] = '{32'd12345678,     "12345678"};

        rst_n   = 1'b0;
        upd_req = 1'b0;
        upd_val = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst en", oled_en, 0);
        checkOutput("rst fields", {oled_cmd, oled_x, oled_y, oled_char_addr}, 0);
        checkOutput("rst ready", ready, 0);
        checkOutput("rst busy", busy, 1);
        checkOutput("rst err", err, 0);

        // Bring-up: init then clear, ready rising right after the clear's one-cycle gap.
        rst_n = 1'b1;
        e1 = 1'b0; e2 = 1'b0; n = 0;
        @(negedge clk);
        while (!ready && n < 1000) begin
            e2 = e1;
            e1 = oled_en;
            @(negedge clk);
            n++;
        end
        checkOutput("bringup ready", ready, 1);
        checkOutput("ready after gap", {e2, e1}, 2'b10);
        checkOutput("bringup busy", busy, 0);
        checkOutput("bringup cmds", logQ.size(), 2);
        checkOutput("init cmd", logQ[0].cmd, 0);
        checkOutput("clear cmd", logQ[1].cmd, 1);
        checkOutput("init-clear gap", gapQ[1], 1);
        checkOutput("init high", hiQ[0], DONE_DLY);

        for (int i = 0; i < 7; i++) begin
            base = logQ.size();
            applyStimulus(vecs[i].val, lat);
            checkOutput($sformatf("vec%0d latency", i), lat, 34);
            waitIdle($sformatf("vec%0d", i), 2000);
            checkRefresh($sformatf("vec%0d", i), base, vecs[i].expChars);
        end

        // A done pulse while idle must be ignored.
        base = logQ.size();
        @(negedge clk); forceDone = 1'b1;
        @(negedge clk); forceDone = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("stray done busy", busy, 0);
        checkOutput("stray done cmds", logQ.size(), base);

        // Two requests during a refresh coalesce into one refresh of the newest value.
        base = logQ.size();
        applyStimulus(32'd1234, lat);
        repeat (100) @(negedge clk);
        pulseReq(32'd5);
        repeat (100) @(negedge clk);
        pulseReq(32'd77);
        waitLog("coalesce", base + 16, 3000);
        waitIdle("coalesce", 2000);
        repeat (600) @(negedge clk);
        checkOutput("coalesce total", logQ.size(), base + 16);
        checkRefresh("coal1234", base, "____1234");
        checkRefresh("coal77", base + 8, "______77");

        // Watchdog: withheld done forces re-init; the request made meanwhile is shown afterwards.
        base = logQ.size();
        withhold = 1'b1;
        applyStimulus(32'd42, lat);
        pulseReq(32'd56);
        n = 0;
        while (oled_en && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tmo en low", oled_en, 0);
        checkOutput("tmo err", err, 1);
        checkOutput("tmo ready", ready, 0);
        checkOutput("tmo busy", busy, 1);
        checkOutput("tmo high len", hiQ[hiQ.size() - 1], TMO);
        @(negedge clk);
        checkOutput("tmo reinit en", oled_en, 1);
        checkOutput("tmo reinit cmd", oled_cmd, 0);
        withhold = 1'b0;
        waitLog("tmo recover", base + 11, 3000);
        waitIdle("tmo recover", 2000);
        checkOutput("tmo digit0 cmd", logQ[base].cmd, 2);
        checkOutput("tmo init cmd", logQ[base + 1].cmd, 0);
        checkOutput("tmo clear cmd", logQ[base + 2].cmd, 1);
        checkRefresh("tmo56", base + 3, "______56");
        checkOutput("err sticky", err, 1);

        // Asynchronous reset in the middle of a command drops en at once.
        applyStimulus(32'd8, lat);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst en", oled_en, 0);
        checkOutput("async rst err", err, 0);
        checkOutput("async rst ready", ready, 0);
        checkOutput("async rst busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!oled_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("restart en", oled_en, 1);
        checkOutput("restart cmd", oled_cmd, 0);

        checkOutput("fields stable under en", stabErr, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
